cmp_stim_checker: RTL and testbench
===================================

// Module: cmp_stim_checker
// PURPOSE
//  On-chip stimulus generator and result checker for the registered equality
//  comparator top. Drives pseudo-random operand pairs a/b (about half forced
//  equal) into the comparator and reads back its registered eq_w. Checks
//  each result against a locally computed expectation and reports pass/fail
//  plus an error count. Sits beside the comparator top in hardware test
//  wrappers, closing the loop without an external pattern source.
// PARAMETERS
//  WIDTH        2          operand width; 1..7 (2*WIDTH <= 15)
//  NUM_VECTORS  256        vectors per run; >= 1
//  DUT_LATENCY  1          DUT clock cycles from operand sampled to eq_w valid
//  LFSR_SEED    16'hACE1   LFSR load value at each run start; must be nonzero
//  ERR_W        8          error counter width
// PORTS
//  clk        in   1       rising-edge clock, shared with DUT
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       run request; sampled only in IDLE or DONE
//  a          out  WIDTH   operand A to DUT (registered)
//  b          out  WIDTH   operand B to DUT (registered)
//  eq_w       in   1       DUT registered equality result
//  busy       out  1       high in RUN and DRAIN
//  done       out  1       high in DONE
//  pass       out  1       done && err_count == 0
//  err_count  out  ERR_W   saturating mismatch count
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, a=b=0, busy=done=pass=0,
//    err_count=0, LFSR=LFSR_SEED, expectation pipe cleared. Applies mid-run too.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift toward MSB. Advances once
//    per issued vector.
//  - Vector from current LFSR value L:
//    - a = L[WIDTH-1:0].
//    - b = L[15] ? L[WIDTH-1:0] : L[2*WIDTH-1:WIDTH].
//    - exp = (a == b).
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    - IDLE/DONE + start on an edge (edge 0): go to RUN; clear err_count,
//      issue counter and expectation pipe; load LFSR_SEED; done=0.
//    - RUN: edges 1..NUM_VECTORS each register one vector onto a/b. Vector k
//      is on a/b after edge k. After edge NUM_VECTORS go to DRAIN and
//      drive a=b=0.
//    - DRAIN: wait for the remaining checks.
//    - Last check at edge NUM_VECTORS+DUT_LATENCY+1, then go to DONE.
//      done rises after that edge.
//    - start in RUN/DRAIN is ignored. start held high in DONE restarts a run.
//  - Check alignment: exp and valid travel through a (DUT_LATENCY+1)-deep
//    shift register. Vector k is compared with eq_w at edge k+DUT_LATENCY+1.
//    Compare only when the valid bit is set; eq_w is don't-care otherwise.
//  - Mismatch: err_count += 1, saturating at 2^ERR_W-1.
//  - Same seed gives a bit-identical sequence on every run.
// CONFIGURATION
//  CMP_STIM_FIRST_ERR_EN defined:
//    - Adds outputs first_err_idx[15:0], first_err_a[WIDTH-1:0],
//      first_err_b[WIDTH-1:0], first_err_vld.
//    - On the first mismatch of a run these capture the 1-based vector index
//      and its operands, and set vld. Later mismatches do not overwrite them.
//    - All four are cleared by reset and by run start.
//  CMP_STIM_FIRST_ERR_EN not defined: these ports and their logic do not exist.
// TESTING (WIDTH=2, NUM_VECTORS=8, DUT_LATENCY=1, ERR_W=8 unless noted)
//  1. Assert reset with a clock running
//     -> a=b=0, busy=done=pass=0, err_count=0 with no clock edge needed.
//  2. Real comparator attached, 1-cycle start pulse
//     -> busy high for 10 edges; a/b match the reference LFSR model;
//        done=1, pass=1, err_count=0 after edge 10.
//  3. eq_w tied 0
//     -> err_count = model's count of equal vectors among the 8; pass=0.
//        With FIRST_ERR_EN, first_err_idx = first equal vector index.
//  4. eq_w = inverted DUT result, ERR_W=2
//     -> err_count saturates at 3; done=1, pass=0.
//  5. reset asserted after edge 4 of a run, then released and start pulsed
//     -> immediate IDLE and zeroed outputs; rerun reproduces test 2 exactly.
//  6. start pulsed at edge 3 of RUN, then again in DONE
//     -> first pulse ignored (done still after edge 10); second pulse
//        restarts, clears err_count, and repeats the same a/b sequence.

Source files
------------

// File: rtl/cmp_stim_checker.sv
// -----------------------------------------------------------------------------
// cmp_stim_checker
//
// Purpose
//   On-chip stimulus generator and result checker for a registered equality
//   comparator. A 16-bit Fibonacci LFSR produces operand pairs a/b, with about
//   half forced equal. Each vector's expected result travels down a short
//   shift register. The expectation is lined up with the comparator's eq_w.
//   Mismatches are counted in a saturating error counter.
//
// Ports
//   clk        in   1       rising-edge clock, shared with the comparator
//   reset      in   1       asynchronous, active-high reset
//   start      in   1       run request, honoured only in IDLE or DONE
//   a          out  WIDTH   operand A to the comparator (registered)
//   b          out  WIDTH   operand B to the comparator (registered)
//   eq_w       in   1       comparator's registered equality result
//   busy       out  1       high while vectors are issued or checks remain
//   done       out  1       high once every check of the run has been made
//   pass       out  1       done with a zero error count
//   err_count  out  ERR_W   saturating mismatch count
//
// Optional feature (macro CMP_STIM_FIRST_ERR_EN)
//   When the macro is defined, four extra outputs are added. They record the
//   first mismatch of a run:
//     first_err_idx  16     1-based index of the vector
//     first_err_a    WIDTH  operand A of that vector
//     first_err_b    WIDTH  operand B of that vector
//     first_err_vld  1      set once a capture has happened
//   When the macro is undefined, these ports and their logic are absent.
// -----------------------------------------------------------------------------
module cmp_stim_checker #(
    parameter int          WIDTH       = 2,
    parameter int          NUM_VECTORS = 256,
    parameter int          DUT_LATENCY = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             eq_w,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef CMP_STIM_FIRST_ERR_EN
    ,
    output logic [15:0]      first_err_idx,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_vld
`endif
);

    // Stage 0 receives the vector as it is issued onto a/b. The last stage
    // lines up with eq_w for that same vector.
    localparam int PIPE_D = DUT_LATENCY + 1;
    localparam int CNT_W  = $clog2(NUM_VECTORS + DUT_LATENCY + 2) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(NUM_VECTORS + DUT_LATENCY);
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [PIPE_D-1:0]   exp_pipe_q, exp_pipe_d;
    logic [PIPE_D-1:0]   vld_pipe_q, vld_pipe_d;
    logic [WIDTH-1:0]    vec_a, vec_b;
    logic                mismatch;

`ifdef CMP_STIM_FIRST_ERR_EN
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(DUT_LATENCY);

    logic [WIDTH-1:0]    a_pipe_q [PIPE_D];
    logic [WIDTH-1:0]    a_pipe_d [PIPE_D];
    logic [WIDTH-1:0]    b_pipe_q [PIPE_D];
    logic [WIDTH-1:0]    b_pipe_d [PIPE_D];
    logic [15:0]         fe_idx_q, fe_idx_d;
    logic [WIDTH-1:0]    fe_a_q, fe_a_d;
    logic [WIDTH-1:0]    fe_b_q, fe_b_d;
    logic                fe_vld_q, fe_vld_d;
`endif

    // Fibonacci step: taps 16,14,13,11. Shifting toward the MSB means the
    // feedback bit enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_ONE;
    endfunction

    // When L[15] is set, b copies a. This makes about half of the vectors
    // equal.
    always_comb begin
        vec_a = lfsr_q[WIDTH-1:0];
        vec_b = lfsr_q[15] ? lfsr_q[WIDTH-1:0] : lfsr_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        a_d        = '0;
        b_d        = '0;
        err_d      = err_q;
        exp_pipe_d = '0;
        vld_pipe_d = '0;
        for (int i = 1; i < PIPE_D; i++) begin
            exp_pipe_d[i] = exp_pipe_q[i-1];
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end

        // eq_w is only meaningful when a real vector sits in the last stage.
        mismatch = vld_pipe_q[PIPE_D-1] && (eq_w != exp_pipe_q[PIPE_D-1]);
        if (mismatch) begin
            err_d = sat_inc(err_q);
        end

`ifdef CMP_STIM_FIRST_ERR_EN
        a_pipe_d[0] = vec_a;
        b_pipe_d[0] = vec_b;
        for (int i = 1; i < PIPE_D; i++) begin
            a_pipe_d[i] = a_pipe_q[i-1];
            b_pipe_d[i] = b_pipe_q[i-1];
        end
        fe_idx_d = fe_idx_q;
        fe_a_d   = fe_a_q;
        fe_b_d   = fe_b_q;
        fe_vld_d = fe_vld_q;
        // The counter keeps running through DRAIN, so it stays DUT_LATENCY
        // ahead of the 1-based index of the vector being checked.
        if (mismatch && !fe_vld_q) begin
            fe_vld_d = 1'b1;
            fe_idx_d = 16'(cnt_q - LAT_CNT);
            fe_a_d   = a_pipe_q[PIPE_D-1];
            fe_b_d   = b_pipe_q[PIPE_D-1];
        end
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    lfsr_d     = LFSR_SEED;
                    cnt_d      = '0;
                    err_d      = '0;
                    exp_pipe_d = '0;
                    vld_pipe_d = '0;
`ifdef CMP_STIM_FIRST_ERR_EN
                    fe_idx_d = '0;
                    fe_a_d   = '0;
                    fe_b_d   = '0;
                    fe_vld_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                a_d           = vec_a;
                b_d           = vec_b;
                exp_pipe_d[0] = (vec_a == vec_b);
                vld_pipe_d[0] = 1'b1;
                lfsr_d        = lfsr_step(lfsr_q);
                cnt_d         = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ISSUE) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CHECK) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            err_q      <= '0;
            exp_pipe_q <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_q      <= err_d;
            exp_pipe_q <= exp_pipe_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

`ifdef CMP_STIM_FIRST_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_idx_q <= '0;
            fe_a_q   <= '0;
            fe_b_q   <= '0;
            fe_vld_q <= 1'b0;
        end else begin
            fe_idx_q <= fe_idx_d;
            fe_a_q   <= fe_a_d;
            fe_b_q   <= fe_b_d;
            fe_vld_q <= fe_vld_d;
        end
    end

    // The operand copies are qualified by vld_pipe_q, so they need no reset.
    always_ff @(posedge clk) begin
        a_pipe_q <= a_pipe_d;
        b_pipe_q <= b_pipe_d;
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_a   = fe_a_q;
    assign first_err_b   = fe_b_q;
    assign first_err_vld = fe_vld_q;
`endif

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = (state_q == S_DONE) && (err_q == '0);
    assign err_count = err_q;

endmodule

// File: tb/tb_cmp_stim_checker.sv
module tb_cmp_stim_checker;

    localparam int W   = 2;
    localparam int N   = 8;
    localparam int L   = 1;
    localparam int EW  = 8;
    localparam int EW2 = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, start2;
    logic [W-1:0]  a, b, a2, b2;
    logic          eq_w, eq_w2, eq_reg, eq_reg2, eq_script;
    logic [1:0]    eq_mode;   // 0 real, 1 scripted, 2 inverted real, 3 tied 0
    logic          busy, done, pass, busy2, done2, pass2;
    logic [EW-1:0] err_count;
    logic [EW2-1:0] err2;

`ifdef CMP_STIM_FIRST_ERR_EN
    logic [15:0]   fe_idx, fe_idx2;
    logic [W-1:0]  fe_a, fe_b, fe_a2, fe_b2;
    logic          fe_vld, fe_vld2;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: vector list derived from the seed.
    logic [W-1:0] m_a [1:N];
    logic [W-1:0] m_b [1:N];
    bit           m_exp [1:N];
    bit           flip [1:N];

    // Observations from the latest run.
    logic [W-1:0] obs_a [1:N];
    logic [W-1:0] obs_b [1:N];
    int           busy_cnt, done_edge;
    logic [EW-1:0] err_e0;
    logic          done_e0;
    logic [W-1:0]  a_drain, b_drain;

    always #5 clk = ~clk;

    // Stand-in for the comparator under test: a registered equality.
    always @(posedge clk) begin
        eq_reg  <= (a == b);
        eq_reg2 <= (a2 == b2);
    end

    assign eq_w = (eq_mode == 2'd0) ? eq_reg :
                  (eq_mode == 2'd2) ? ~eq_reg :
                  (eq_mode == 2'd1) ? eq_script : 1'b0;
    assign eq_w2 = ~eq_reg2;

    cmp_stim_checker #(.WIDTH(W), .NUM_VECTORS(N), .DUT_LATENCY(L),
                       .LFSR_SEED(16'hACE1), .ERR_W(EW)) u_dut (
        .clk(clk), .reset(rst), .start(start), .a(a), .b(b), .eq_w(eq_w),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef CMP_STIM_FIRST_ERR_EN
        , .first_err_idx(fe_idx), .first_err_a(fe_a), .first_err_b(fe_b),
        .first_err_vld(fe_vld)
`endif
    );

    cmp_stim_checker #(.WIDTH(W), .NUM_VECTORS(N), .DUT_LATENCY(L),
                       .LFSR_SEED(16'hACE1), .ERR_W(EW2)) u_sat (
        .clk(clk), .reset(rst), .start(start2), .a(a2), .b(b2), .eq_w(eq_w2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef CMP_STIM_FIRST_ERR_EN
        , .first_err_idx(fe_idx2), .first_err_a(fe_a2), .first_err_b(fe_b2),
        .first_err_vld(fe_vld2)
`endif
    );

    // Walk the seed forward with integer arithmetic. a is L mod 2^W. When bit
    // 15 is set, b is a copy of a; otherwise b is the next W bits of L.
    task automatic build_model();
        int l;
        int fb;
        l = 'hACE1;
        for (int k = 1; k <= N; k++) begin
            m_a[k]   = W'(l % (1 << W));
            m_b[k]   = ((l >> 15) & 1) != 0 ? W'(l % (1 << W)) : W'((l >> W) % (1 << W));
            m_exp[k] = (m_a[k] == m_b[k]);
            fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
            l  = ((l << 1) | fb) & 'hFFFF;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete run: start edge (edge 0) then edges 1..N+L+1.
    task automatic run_one(input bit pulse_at3, input bit with_sat);
        start  = 1'b1;
        start2 = with_sat;
        step();
        start  = 1'b0;
        start2 = 1'b0;
        busy_cnt  = busy ? 1 : 0;
        done_edge = -1;
        err_e0    = err_count;
        done_e0   = done;
        for (int e = 1; e <= N + L + 1; e++) begin
            if (e - 2 >= 1 && e - 2 <= N)
                eq_script = m_exp[e-2] ^ flip[e-2];
            else
                eq_script = 1'($urandom_range(0, 1));
            start = pulse_at3 && (e == 3);
            step();
            start = 1'b0;
            if (e <= N) begin
                obs_a[e] = a;
                obs_b[e] = b;
            end
            if (e == N + 1) begin
                a_drain = a;
                b_drain = b;
            end
            if (busy) busy_cnt++;
            if (done && done_edge < 0) done_edge = e;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start2 = 1'b0; eq_mode = 2'd0; eq_script = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_vec++; if (a !== '0)         begin n_bad++; $display("FAIL reset_a got %0d want 0", a); end
        n_vec++; if (b !== '0)         begin n_bad++; $display("FAIL reset_b got %0d want 0", b); end
        n_vec++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (pass !== 1'b0)    begin n_bad++; $display("FAIL reset_pass got %b want 0", pass); end
        n_vec++; if (err_count !== '0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err_count); end
        n_vec++; if (err2 !== '0)      begin n_bad++; $display("FAIL reset_err2 got %0d want 0", err2); end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic check_sequence(input string tag);
        for (int k = 1; k <= N; k++) begin
            n_vec++;
            if (obs_a[k] !== m_a[k] || obs_b[k] !== m_b[k]) begin
                n_bad++;
                $display("FAIL %s_vec%0d got a=%0d b=%0d want a=%0d b=%0d",
                         tag, k, obs_a[k], obs_b[k], m_a[k], m_b[k]);
            end
        end
    endtask

    task automatic test_real_comparator();
        eq_mode = 2'd0;
        for (int k = 1; k <= N; k++) flip[k] = 1'b0;
        run_one(1'b0, 1'b0);
        check_sequence("real");
        n_vec++; if (busy_cnt != N + L + 1) begin n_bad++; $display("FAIL real_busy_edges got %0d want %0d", busy_cnt, N + L + 1); end
        n_vec++; if (done_edge != N + L + 1) begin n_bad++; $display("FAIL real_done_edge got %0d want %0d", done_edge, N + L + 1); end
        n_vec++; if (a_drain !== '0 || b_drain !== '0) begin n_bad++; $display("FAIL real_drain_ab got a=%0d b=%0d want 0 0", a_drain, b_drain); end
        n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL real_pass got %b want 1", pass); end
        n_vec++; if (err_count !== '0) begin n_bad++; $display("FAIL real_err got %0d want 0", err_count); end
    endtask

    task automatic test_eq_tied0();
        int n_eq;
        int first;
        eq_mode = 2'd3;
        n_eq = 0;
        first = 0;
        for (int k = N; k >= 1; k--) begin
            if (m_exp[k]) begin
                n_eq++;
                first = k;
            end
        end
        run_one(1'b0, 1'b0);
        n_vec++; if (int'(err_count) != n_eq) begin n_bad++; $display("FAIL tied0_err got %0d want %0d", err_count, n_eq); end
        n_vec++; if (pass !== (n_eq == 0)) begin n_bad++; $display("FAIL tied0_pass got %b want %b", pass, n_eq == 0); end
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL tied0_done got %b want 1", done); end
`ifdef CMP_STIM_FIRST_ERR_EN
        n_vec++; if (fe_vld !== (n_eq != 0)) begin n_bad++; $display("FAIL tied0_fe_vld got %b want %b", fe_vld, n_eq != 0); end
        if (n_eq != 0) begin
            n_vec++;
            if (int'(fe_idx) != first || fe_a !== m_a[first] || fe_b !== m_b[first]) begin
                n_bad++;
                $display("FAIL tied0_first_err got idx=%0d a=%0d b=%0d want idx=%0d a=%0d b=%0d",
                         fe_idx, fe_a, fe_b, first, m_a[first], m_b[first]);
            end
        end
`endif
    endtask

    task automatic test_saturation();
        eq_mode = 2'd2;
        run_one(1'b0, 1'b1);
        n_vec++; if (int'(err_count) != N) begin n_bad++; $display("FAIL inv_err8 got %0d want %0d", err_count, N); end
        n_vec++; if (err2 !== 2'd3) begin n_bad++; $display("FAIL sat_err2 got %0d want 3", err2); end
        n_vec++; if (done2 !== 1'b1) begin n_bad++; $display("FAIL sat_done2 got %b want 1", done2); end
        n_vec++; if (pass2 !== 1'b0) begin n_bad++; $display("FAIL sat_pass2 got %b want 0", pass2); end
        n_vec++; if (pass !== 1'b0) begin n_bad++; $display("FAIL inv_pass got %b want 0", pass); end
    endtask

    task automatic test_random_flips();
        int exp_err;
        int first;
        eq_mode = 2'd1;
        for (int it = 0; it < 6; it++) begin
            exp_err = 0;
            first = 0;
            for (int k = N; k >= 1; k--) begin
                flip[k] = ($urandom_range(0, 2) == 0);
                if (flip[k]) begin
                    exp_err++;
                    first = k;
                end
            end
            if (exp_err > (1 << EW) - 1) exp_err = (1 << EW) - 1;
            run_one(1'b0, 1'b0);
            check_sequence("rand");
            n_vec++; if (int'(err_count) != exp_err) begin n_bad++; $display("FAIL rand_err it%0d got %0d want %0d", it, err_count, exp_err); end
            n_vec++; if (pass !== (exp_err == 0)) begin n_bad++; $display("FAIL rand_pass it%0d got %b want %b", it, pass, exp_err == 0); end
`ifdef CMP_STIM_FIRST_ERR_EN
            if (exp_err != 0) begin
                n_vec++;
                if (fe_vld !== 1'b1 || int'(fe_idx) != first || fe_a !== m_a[first] || fe_b !== m_b[first]) begin
                    n_bad++;
                    $display("FAIL rand_first_err it%0d got vld=%b idx=%0d want idx=%0d", it, fe_vld, fe_idx, first);
                end
            end
`endif
        end
        for (int k = 1; k <= N; k++) flip[k] = 1'b0;
    endtask

    task automatic test_reset_midrun();
        eq_mode = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_vec++; if (a !== '0 || b !== '0) begin n_bad++; $display("FAIL midrst_ab got a=%0d b=%0d want 0 0", a, b); end
        n_vec++; if (done !== 1'b0 || pass !== 1'b0 || err_count !== '0) begin
            n_bad++; $display("FAIL midrst_status got done=%b pass=%b err=%0d want 0 0 0", done, pass, err_count);
        end
        step();
        rst = 1'b0;
        run_one(1'b0, 1'b0);
        check_sequence("rerun");
        n_vec++; if (done_edge != N + L + 1) begin n_bad++; $display("FAIL rerun_done_edge got %0d want %0d", done_edge, N + L + 1); end
        n_vec++; if (pass !== 1'b1 || err_count !== '0) begin n_bad++; $display("FAIL rerun_pass got pass=%b err=%0d want 1 0", pass, err_count); end
    endtask

    task automatic test_back_to_back();
        int n_eq;
        n_eq = 0;
        for (int k = 1; k <= N; k++) if (m_exp[k]) n_eq++;
        eq_mode = 2'd3;
        run_one(1'b1, 1'b0);
        n_vec++; if (done_edge != N + L + 1) begin n_bad++; $display("FAIL b2b_ignored_done_edge got %0d want %0d", done_edge, N + L + 1); end
        n_vec++; if (busy_cnt != N + L + 1) begin n_bad++; $display("FAIL b2b_busy_edges got %0d want %0d", busy_cnt, N + L + 1); end
        n_vec++; if (int'(err_count) != n_eq) begin n_bad++; $display("FAIL b2b_err1 got %0d want %0d", err_count, n_eq); end
        check_sequence("b2b1");
        eq_mode = 2'd0;
        run_one(1'b0, 1'b0);
        n_vec++; if (err_e0 !== '0) begin n_bad++; $display("FAIL b2b_err_cleared got %0d want 0", err_e0); end
        n_vec++; if (done_e0 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_cleared got %b want 0", done_e0); end
        check_sequence("b2b2");
        n_vec++; if (pass !== 1'b1 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_pass got pass=%b done=%b want 1 1", pass, done); end
    endtask

    initial begin
        build_model();
        for (int k = 1; k <= N; k++) flip[k] = 1'b0;
        test_reset();
        test_real_comparator();
        test_eq_tied0();
        test_saturation();
        test_random_flips();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
